unary_tape_encoder: RTL and testbench

Frame writer for the unary-addition tape machine. Accepts two binary operands over a valid/ready handshake and streams the corresponding tape image, one 2-bit symbol per handshake: leading blanks, `a` copies of A, one ADD, `b` copies of A, trailing blanks. It sits upstream of the tape-processing machine and is the producer of the tape format that machine consumes.

---
 rtl/tape_sym_pkg.sv | 29 ++
 rtl/unary_run_counter.sv | 31 +++
 rtl/unary_tape_encoder.sv | 162 ++++++++++++++++
 tb/tb_unary_tape_encoder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tape_sym_pkg.sv
// Shared tape-format definitions for the unary-addition tape encoder and the tape machine.
// Symbol encodings, symbol type, and the frame-writer FSM state enum.
package tape_sym_pkg;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_A     = 2'b00;
    localparam sym_t SYM_ADD   = 2'b01;
    localparam sym_t SYM_BLANK = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        OPA,
        SEP,
        OPB,
        TRAIL
    } state_t;

    // Symbol emitted while a segment is active; IDLE parks the line at BLANK.
    function automatic sym_t seg_sym(input state_t s);
        case (s)
            OPA, OPB: return SYM_A;
            SEP:      return SYM_ADD;
            default:  return SYM_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/unary_run_counter.sv
// Loadable down-counter shared by every segment of a tape frame.
// Holds at zero instead of wrapping.
module unary_run_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] len,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= len;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/unary_tape_encoder.sv
// Frame writer: BLANK*LEAD, A*op_a, ADD, A*op_b, BLANK*TRAIL, one symbol per handshake.
// Define UNARY_TAPE_ENCODER_IDX_EN to add the sym_idx cell-index output.
module unary_tape_encoder
    import tape_sym_pkg::*;
#(
    parameter int unsigned OP_W         = 4,
    parameter int unsigned LEAD_BLANKS  = 6,
    parameter int unsigned TRAIL_BLANKS = 5,
    localparam int unsigned IDX_W =
        $clog2(LEAD_BLANKS + 2 * ((1 << OP_W) - 1) + 1 + TRAIL_BLANKS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op_a,
    input  logic [OP_W-1:0] op_b,
    output logic            sym_valid,
    input  logic            sym_ready,
    output sym_t            sym,
`ifdef UNARY_TAPE_ENCODER_IDX_EN
    output logic [IDX_W-1:0] sym_idx,
`endif
    output logic            sym_last
);

    localparam int unsigned BLK_MAX = (LEAD_BLANKS > TRAIL_BLANKS) ? LEAD_BLANKS : TRAIL_BLANKS;
    localparam int unsigned BLK_W   = $clog2(BLK_MAX + 1);
    localparam int unsigned CNT_W   = (OP_W > BLK_W) ? OP_W : BLK_W;

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    sym_t            sym_q, sym_d;
    logic            sym_valid_q, sym_valid_d;
    logic            sym_last_q, sym_last_d;
    logic            in_ready_q, in_ready_d;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_len, cnt_val;
    logic             hs;

    assign hs = sym_valid_q && sym_ready;

    // The counter holds the cells remaining after the one on sym, so zero marks a segment's last cell.
    unary_run_counter #(.W(CNT_W)) u_run (
        .clk  (clk),
        .rst_n(rst_n),
        .load (cnt_load),
        .len  (cnt_len),
        .dec  (cnt_dec),
        .cnt  (cnt_val),
        .zero (cnt_zero)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sym_valid_d = sym_valid_q;
        sym_last_d  = sym_last_q;
        in_ready_d  = in_ready_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_len     = '0;

        if (state_q == IDLE) begin
            if (in_valid && in_ready_q) begin
                op_a_d      = op_a;
                op_b_d      = op_b;
                state_d     = LEAD;
                cnt_load    = 1'b1;
                cnt_len     = CNT_W'(LEAD_BLANKS - 1);
                sym_valid_d = 1'b1;
                in_ready_d  = 1'b0;
            end
        end else if (hs) begin
            if (!cnt_zero) begin
                cnt_dec    = 1'b1;
                sym_last_d = (state_q == TRAIL) && (cnt_val == CNT_W'(1));
            end else begin
                cnt_load = 1'b1;
                unique case (state_q)
                    LEAD: begin
                        state_d = (op_a_q != '0) ? OPA : SEP;
                        cnt_len = (op_a_q != '0) ? CNT_W'(op_a_q) - CNT_W'(1) : '0;
                    end
                    OPA: begin
                        state_d = SEP;
                    end
                    SEP, OPB: begin
                        if ((state_q == SEP) && (op_b_q != '0)) begin
                            state_d = OPB;
                            cnt_len = CNT_W'(op_b_q) - CNT_W'(1);
                        end else begin
                            state_d    = TRAIL;
                            cnt_len    = CNT_W'(TRAIL_BLANKS - 1);
                            sym_last_d = (TRAIL_BLANKS == 1);
                        end
                    end
                    default: begin
                        state_d     = IDLE;
                        sym_valid_d = 1'b0;
                        sym_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    assign sym_d = seg_sym(state_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sym_q       <= SYM_BLANK;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            sym_last_q  <= sym_last_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef UNARY_TAPE_ENCODER_IDX_EN
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (state_q == IDLE) begin
            idx_d = '0;
        end else if (hs) begin
            idx_d = (state_d == IDLE) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign sym_idx = idx_q;
`endif

    assign in_ready  = in_ready_q;
    assign sym_valid = sym_valid_q;
    assign sym       = sym_q;
    assign sym_last  = sym_last_q;

endmodule

// File: tb/tb_unary_tape_encoder.sv
// Directed bench for unary_tape_encoder: golden tape images, backpressure, back-to-back and reset abort.
// Checks sym_idx too when UNARY_TAPE_ENCODER_IDX_EN is defined.
module tb_unary_tape_encoder;
    import tape_sym_pkg::*;

    localparam int OP_W = 4;
    localparam int LB   = 6;
    localparam int TB   = 5;
    localparam int IDX_W = $clog2(LB + 2 * ((1 << OP_W) - 1) + 1 + TB);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [OP_W-1:0] op_a = '0;
    logic [OP_W-1:0] op_b = '0;
    logic            sym_valid;
    logic            sym_ready = 1'b1;
    sym_t            sym;
    logic            sym_last;
`ifdef UNARY_TAPE_ENCODER_IDX_EN
    logic [IDX_W-1:0] sym_idx;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unary_tape_encoder #(.OP_W(OP_W), .LEAD_BLANKS(LB), .TRAIL_BLANKS(TB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .sym      (sym),
`ifdef UNARY_TAPE_ENCODER_IDX_EN
        .sym_idx  (sym_idx),
`endif
        .sym_last (sym_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic sym_t golden(input int a, input int b, input int idx);
        if (idx < LB)             return SYM_BLANK;
        if (idx < LB + a)         return SYM_A;
        if (idx == LB + a)        return SYM_ADD;
        if (idx < LB + a + 1 + b) return SYM_A;
        return SYM_BLANK;
    endfunction

    // Runs one frame from a negedge with in_ready expected; returns at the negedge after the last handshake.
    task automatic frame(input int a, input int b, input bit rnd, input bit hold,
                         input int next_a, input int next_b);
        int   len = LB + a + 1 + b + TB;
        int   idx = 0;
        int   wait_cyc = 0;
        bit   rdy;
        bit   stalled = 1'b0;
        sym_t prev_sym = SYM_BLANK;
        logic prev_last = 1'b0;

        while (!in_ready && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("accept_ready", in_ready, 1);
        op_a     = OP_W'(a);
        op_b     = OP_W'(b);
        in_valid = 1'b1;
        sym_ready = 1'b1;
        @(negedge clk);
        if (hold) begin
            op_a = OP_W'(next_a);
            op_b = OP_W'(next_b);
        end else begin
            in_valid = 1'b0;
        end
        check("first_valid", sym_valid, 1);

        for (int cyc = 0; cyc < 500 && idx < len; cyc++) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sym_ready = rdy;
            if (stalled) begin
                check("stall_valid", sym_valid, 1);
                check("stall_sym", sym, prev_sym);
                check("stall_last", sym_last, prev_last);
            end
            if (sym_valid) check("busy_in_ready", in_ready, 0);
            if (sym_valid && rdy) begin
                check($sformatf("sym[%0d]", idx), sym, golden(a, b, idx));
                check($sformatf("last[%0d]", idx), sym_last, (idx == len - 1));
`ifdef UNARY_TAPE_ENCODER_IDX_EN
                check($sformatf("idx[%0d]", idx), sym_idx, idx);
`endif
                idx++;
            end
            stalled   = sym_valid && !rdy;
            prev_sym  = sym;
            prev_last = sym_last;
            @(negedge clk);
        end
        check("frame_len", idx, len);
        check("done_valid", sym_valid, 0);
        check("done_ready", in_ready, 1);
        sym_ready = 1'b1;
    endtask

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_valid", sym_valid, 0);
        check("rst_sym", sym, SYM_BLANK);
        check("rst_last", sym_last, 0);
        rst_n = 1'b1;
        @(negedge clk);

        frame(3, 4, 1'b0, 1'b0, 0, 0);
        frame(0, 0, 1'b0, 1'b0, 0, 0);
        frame(15, 15, 1'b0, 1'b0, 0, 0);
        frame(2, 1, 1'b1, 1'b0, 0, 0);

        // Back-to-back: in_valid stays high and the pins change to (0,2) while frame 1 runs.
        frame(1, 1, 1'b0, 1'b1, 0, 2);
        frame(0, 2, 1'b0, 1'b0, 0, 0);

        // Reset abort while cell 8 of a (3,4) frame is presented.
        op_a     = 4'd3;
        op_b     = 4'd4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_abort_sym", sym, SYM_A);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_valid", sym_valid, 0);
        check("abort_sym", sym, SYM_BLANK);
        check("abort_last", sym_last, 0);
`ifdef UNARY_TAPE_ENCODER_IDX_EN
        check("abort_idx", sym_idx, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(3, 4, 1'b0, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
